bram_fifo_ctrl: RTL



---
 rtl/bram_fifo_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external simple-dual-port RAM
// with one cycle of read latency. Writes go to RAM port A and reads come from
// port B. A two-entry output queue hides the RAM read latency, so the head of
// the queue is presented combinationally on out_data.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where valid and ready are both high. in_ready never looks at out_ready.
// out_valid depends only on registered state. Neither side may retract
// valid before the transfer completes.
module bram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [AW-1:0]         ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [AW-1:0]         ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         ram_cnt;
    logic                  inflight;
    logic [1:0]            oq_cnt;
    logic [DATA_WIDTH-1:0] oq0;
    logic [DATA_WIDTH-1:0] oq1;
    logic [DATA_WIDTH-1:0] oq0_nxt;
    logic [DATA_WIDTH-1:0] oq1_nxt;
    logic [1:0]            oq_after_pop;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;

    // Occupancy counts RAM entries, the read in flight and the staged entries
    assign count = ram_cnt
                 + {{(CW-1){1'b0}}, inflight}
                 + {{(CW-2){1'b0}}, oq_cnt};

    assign in_ready  = (count < CW'(DEPTH)) && !rst && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = (oq_cnt != 2'd0);
    assign out_data  = oq0;
    assign pop       = out_valid && out_ready && !flush;

    // A read is issued only when the staging queue is certain to have room
    // for its data the following cycle, counting the slot freed by this pop.
    assign oq_after_pop = oq_cnt - {1'b0, pop};
    assign rd_issue     = (ram_cnt != '0)
                        && ((oq_after_pop + {1'b0, inflight}) < 2'd2)
                        && !flush && !rst;

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wptr;
    assign ram_dina  = in_data;
    assign ram_enb   = rd_issue;
    assign ram_addrb = rptr;

    // Pointers, RAM occupancy and the read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_issue) begin
                rptr <= rptr + AW'(1);
            end
            inflight <= rd_issue;
            case ({push, rd_issue})
                2'b10:   ram_cnt <= ram_cnt + CW'(1);
                2'b01:   ram_cnt <= ram_cnt - CW'(1);
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

    // Next staging contents: shift out on pop, then append returning RAM data
    always_comb begin
        oq0_nxt = oq0;
        oq1_nxt = oq1;
        if (pop) begin
            oq0_nxt = oq1;
        end
        if (inflight) begin
            if (oq_after_pop == 2'd0) begin
                oq0_nxt = ram_doutb;
            end else begin
                oq1_nxt = ram_doutb;
            end
        end
    end

    // Output staging registers; flush drops any RAM data still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oq_cnt <= 2'd0;
            oq0    <= '0;
            oq1    <= '0;
        end else if (flush) begin
            oq_cnt <= 2'd0;
        end else begin
            oq_cnt <= oq_after_pop + {1'b0, inflight};
            oq0    <= oq0_nxt;
            oq1    <= oq1_nxt;
        end
    end

endmodule
